// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// full-width product (2*WIDTH bits) delivered with a single-cycle done pulse.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Res,
   output logic [1:0]         dbg_state
);

   // Handshake: start is sampled only in IDLE or DONE; once accepted, busy is
   // high for exactly WIDTH cycles, then done pulses for one cycle with Res
   // already holding the product. start during RUN is ignored, never queued.
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] shifted;
   logic               last;

   // acc_lo starts as the multiplier and is consumed LSB first while product
   // bits shift in from the top, so after WIDTH steps {acc_hi, acc_lo} = A*B.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      shifted = {sum, acc_lo[WIDTH-1:1]};
      last    = (cnt == LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Res    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mcand  <= A;
                  acc_hi <= '0;
                  acc_lo <= B;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc_hi <= shifted[2*WIDTH-1:WIDTH];
               acc_lo <= shifted[WIDTH-1:0];
               cnt    <= cnt + CW'(1);
               if (last) begin
                  Res   <= shifted;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=8 and WIDTH=32: drivers push
// reference products, per-instance monitors pop and compare on done.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] res8;
   logic [1:0]  st8;
   logic        start32, busy32, done32;
   logic [31:0] a32, b32;
   logic [63:0] res32;
   logic [1:0]  st32;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_q8[$];
   logic [63:0] exp_q32[$];

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .Res(res8), .dbg_state(st8)
   );

   seq_multiplier #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .A(a32), .B(b32),
      .busy(busy32), .done(done32), .Res(res32), .dbg_state(st32)
   );

   // Reference model: exact unsigned product at double width.
   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
      return {8'b0, a} * {8'b0, b};
   endfunction

   function automatic logic [63:0] mul32(input logic [31:0] a, input logic [31:0] b);
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic bit get_done(input bit w);
      return w ? done32 : done8;
   endfunction

   function automatic bit get_busy(input bit w);
      return w ? busy32 : busy8;
   endfunction

   // Drive one start pulse at the negedge; returns #1 after the accepting edge.
   task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      if (w) begin
         start32 = 1'b1; a32 = a[31:0]; b32 = b[31:0];
         exp_q32.push_back(mul32(a[31:0], b[31:0]));
      end else begin
         start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
         exp_q8.push_back(mul8(a[7:0], b[7:0]));
      end
      @(posedge clk);
      #1;
      // Scramble operands so a design that fails to capture them is caught.
      if (w) begin
         start32 = 1'b0; a32 = $urandom; b32 = $urandom;
      end else begin
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
   endtask

   // Wait for done (bounded); optionally check latency and busy width.
   task automatic wait_done(input bit w, input int width, input bit timing);
      int  n;
      int  bc;
      bit  seen;
      n = 0;
      seen = 1'b0;
      bc = get_busy(w) ? 1 : 0;
      for (int i = 0; i < width + 20; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (get_done(w)) begin
            seen = 1'b1;
            break;
         end
         if (get_busy(w)) bc++;
      end
      check("done_seen", 64'(seen), 64'd1);
      if (seen && timing) begin
         check("latency", 64'(n), 64'(width));
         check("busy_cycles", 64'(bc), 64'(width));
      end
   endtask

   // Monitors: pop and compare on every done; enforce one-cycle done,
   // busy low while done, and Res stable outside completion edges.
   bit          d8_prev, d32_prev;
   logic [15:0] r8_last;
   logic [63:0] r32_last;
   logic [15:0] e8;
   logic [63:0] e32;

   always @(negedge clk) begin
      if (rst_n) begin
         if (done8) begin
            if (exp_q8.size() == 0) begin
               checks++; failures++;
               $display("FAIL res8_unexpected_done got=0x%0h expected=no_done", res8);
            end else begin
               e8 = exp_q8.pop_front();
               check("res8", 64'(res8), 64'(e8));
            end
            check("done8_single", 64'(d8_prev), 64'd0);
            check("busy8_low_at_done", 64'(busy8), 64'd0);
         end else begin
            check("res8_stable", 64'(res8), 64'(r8_last));
         end
         if (done32) begin
            if (exp_q32.size() == 0) begin
               checks++; failures++;
               $display("FAIL res32_unexpected_done got=0x%0h expected=no_done", res32);
            end else begin
               e32 = exp_q32.pop_front();
               check("res32", res32, e32);
            end
            check("done32_single", 64'(d32_prev), 64'd0);
            check("busy32_low_at_done", 64'(busy32), 64'd0);
         end else begin
            check("res32_stable", res32, r32_last);
         end
      end
      d8_prev  = done8;
      d32_prev = done32;
      r8_last  = res8;
      r32_last = res32;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dc;
      logic [63:0] ra, rb;
      int sel;

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start32 = 1'b0; a32 = '0; b32 = '0;
      #2;
      check("reset_busy8", 64'(busy8), 64'd0);
      check("reset_done8", 64'(done8), 64'd0);
      check("reset_res8", 64'(res8), 64'd0);
      check("reset_state8", 64'(st8), 64'd0);
      check("reset_res32", res32, 64'd0);
      check("reset_busy32", 64'(busy32), 64'd0);
      #20;
      rst_n = 1'b1;

      // Directed products.
      issue(0, 3, 5);       wait_done(0, 8, 1);  check("res_3x5", 64'(res8), 64'd15);
      issue(0, 255, 255);   wait_done(0, 8, 1);  check("res_255x255", 64'(res8), 64'hFE01);
      issue(1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_done(1, 32, 1);
      check("res_max32", res32, 64'hFFFF_FFFE_0000_0001);
      issue(0, 0, 200);     wait_done(0, 8, 1);  check("res_0x200", 64'(res8), 64'd0);
      issue(0, 200, 0);     wait_done(0, 8, 1);  check("res_200x0", 64'(res8), 64'd0);

      // start held high; operands change in the DONE cycle.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
      exp_q8.push_back(mul8(8'd7, 8'd9));
      @(posedge clk); #1;
      n = 0;
      while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
      check("held_first_latency", 64'(n), 64'd8);
      check("held_first_res", 64'(res8), 64'd63);
      a8 = 8'd12; b8 = 8'd11;
      exp_q8.push_back(mul8(8'd12, 8'd11));
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 50) begin @(posedge clk); #1; n++; end
      check("held_spacing", 64'(n), 64'd9);
      check("held_second_res", 64'(res8), 64'd132);

      // start pulse and operand change during RUN are ignored.
      issue(0, 7, 9);
      @(posedge clk); #1;
      start8 = 1'b1; a8 = 8'd99; b8 = 8'd99;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done(0, 8, 0);
      check("run_restart_ignored", 64'(res8), 64'd63);
      dc = 0;
      repeat (12) begin @(posedge clk); #1; if (done8) dc++; end
      check("no_extra_done_after_run_start", 64'(dc), 64'd0);

      // Asynchronous reset mid-RUN aborts silently.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd10; b8 = 8'd10;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy_before_abort", 64'(busy8), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      check("abort_res", 64'(res8), 64'd0);
      check("abort_state", 64'(st8), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      repeat (20) begin @(posedge clk); #1; if (done8) dc++; end
      check("no_done_after_abort", 64'(dc), 64'd0);
      check("res_kept_zero", 64'(res8), 64'd0);
      issue(0, 10, 10);     wait_done(0, 8, 1);  check("res_after_abort", 64'(res8), 64'd100);

      // Random operands with boundary bias and random idle gaps (0 = restart in DONE).
      for (int i = 0; i < 1000; i++) begin
         sel = $urandom_range(0, 9);
         ra = (sel == 0) ? 64'd0 : (sel == 1) ? 64'd255 : 64'($urandom_range(0, 255));
         rb = (sel == 2) ? 64'd0 : (sel == 3) ? 64'd255 : 64'($urandom_range(0, 255));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         issue(0, ra, rb);
         wait_done(0, 8, 1);
      end
      for (int i = 0; i < 1000; i++) begin
         sel = $urandom_range(0, 9);
         ra = (sel == 0) ? 64'd0 : (sel == 1) ? 64'hFFFF_FFFF : 64'($urandom);
         rb = (sel == 2) ? 64'd0 : (sel == 3) ? 64'hFFFF_FFFF : 64'($urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         issue(1, ra, rb);
         wait_done(1, 32, 1);
      end

      repeat (4) @(posedge clk);
      #1;
      check("q8_drained", 64'(exp_q8.size()), 64'd0);
      check("q32_drained", 64'(exp_q32.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-and-add multiplier; the arithmetic counterpart of the team's restoring divider. Computes Res = A*B at full width (2*WIDTH bits), one multiplier bit per clock. Sits beside the divider in the arithmetic datapath, using a start/done handshake so a caller can trade latency for area.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  multiplicand, unsigned; captured on accepted start.
- B  in  WIDTH  multiplier, unsigned; captured on accepted start.
- busy  out  1  high while a multiplication is in progress (state RUN).
- done  out  1  single-cycle pulse; Res holds the new product while high.
- Res  out  2*WIDTH  product register; holds its value until the next completion.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1: capture mcand<=A; {acc_hi, acc_lo}<={WIDTH zeros, B}; cnt<=0; go to RUN. IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - sum = acc_hi + (acc_lo[0] ? mcand : 0), computed WIDTH+1 bits wide (carry kept).
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 1 (logical right shift).
  - cnt <= cnt+1.
  - When cnt = WIDTH-1: Res <= shifted value, go to DONE.
- DONE, one cycle: done=1. start=1 is accepted exactly as in IDLE (next state RUN). Otherwise go to IDLE.
- start during RUN is ignored: no restart, no queuing.
- A/B changes after capture have no effect on the current product.
- Arithmetic is exact unsigned. No overflow is possible. Res = 0 for any zero operand.
- cnt width = clog2(WIDTH)+1 bits.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, Res=0, internal registers=0. Takes effect immediately, including mid-RUN. An aborted operation never asserts done, and Res keeps 0.
- Reset release: first start is accepted on the first rising edge with rst_n=1.
- Latency: start sampled high at edge E0 -> busy=1 after E0 -> Res valid and done=1 after edge E0+WIDTH -> done=0 after E0+WIDTH+1 (unless restarted).
- busy is high for exactly WIDTH cycles and is low while done=1.
- Throughput: back-to-back, with start held or re-asserted in the DONE cycle, gives one result every WIDTH+1 cycles.
- Res changes only on the completion edge or on reset.

## Test plan
- WIDTH=8, A=3, B=5, start pulse -> busy 8 cycles; done pulse on 9th edge after start; Res=15.
- WIDTH=8, A=255, B=255 -> Res=65025 (0xFE01). Also WIDTH=32, A=B=0xFFFFFFFF -> Res=0xFFFFFFFE00000001.
- WIDTH=8, A=0, B=200, then A=200, B=0 -> Res=0 both times; done pulses twice.
- WIDTH=8, start held high continuously with A=7, B=9, then A=12, B=11 changed in the DONE cycle -> Res=63 then Res=132; done pulses spaced 9 cycles apart. Also: a start pulse plus operand change during RUN does not alter 63.
- WIDTH=8, A=10, B=10, rst_n pulled low 4 cycles after start -> busy, done, Res drop to 0 immediately; no done pulse afterwards. A new start after release gives Res=100.
- Random unsigned operands for WIDTH=8 and 32 (at least 1000 each) -> Res equals the reference A*B; each done is exactly one cycle wide.
